// File: rtl/id_table.sv
// ---------------------------------------------------------------------------
// id_table
//
// Small fully-associative table of IDs. Slots are allocated lowest-free-first,
// released individually by index, or invalidated all at once by flush. A
// lookup searches every valid slot and returns the lowest matching index one
// cycle later.
//
// Parameters
//   ID_WIDTH   width of each stored ID
//   NUM_ID     number of slots (>= 2)
//   IDX_WIDTH  width of slot indices and of count; value NUM_ID means "none"
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   alloc_valid/alloc_ready        insert handshake
//   alloc_id, alloc_idx            ID to store, slot that will receive it
//   free_valid, free_idx           release one slot
//   flush                          invalidate every slot (IDs are kept)
//   lookup_valid, lookup_id        search request
//   resp_valid, resp_hit, resp_idx registered search result
//   id_array_out, valid_out        stored IDs and slot-valid bits
//   count, full, empty             occupancy
//   err                            sticky protocol-error flag
//
// Optional feature
//   ID_TABLE_ERR_CHECK_EN  when defined, err latches on a bad free or an
//                          alloc attempt while full; otherwise err is 0.
// ---------------------------------------------------------------------------
module id_table #(
    parameter int ID_WIDTH  = 8,
    parameter int NUM_ID    = 8,
    parameter int IDX_WIDTH = $clog2(NUM_ID + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alloc_valid,
    output logic                 alloc_ready,
    input  logic [ID_WIDTH-1:0]  alloc_id,
    output logic [IDX_WIDTH-1:0] alloc_idx,
    input  logic                 free_valid,
    input  logic [IDX_WIDTH-1:0] free_idx,
    input  logic                 flush,
    input  logic                 lookup_valid,
    input  logic [ID_WIDTH-1:0]  lookup_id,
    output logic                 resp_valid,
    output logic                 resp_hit,
    output logic [IDX_WIDTH-1:0] resp_idx,
    output logic [ID_WIDTH-1:0]  id_array_out [NUM_ID-1:0],
    output logic [NUM_ID-1:0]    valid_out,
    output logic [IDX_WIDTH-1:0] count,
    output logic                 full,
    output logic                 empty,
    output logic                 err
);

    localparam logic [IDX_WIDTH-1:0] NONE_IDX = IDX_WIDTH'(NUM_ID);

    logic [NUM_ID-1:0]    alloc_mask;
    logic [NUM_ID-1:0]    free_mask;
    logic                 alloc_fire;
    logic                 free_ok;
    logic [IDX_WIDTH-1:0] count_next;
    logic                 lookup_hit;
    logic [IDX_WIDTH-1:0] lookup_idx;

    // Occupancy flags come straight off the count register, and an alloc is
    // refused while full or while a flush is wiping the table. A same-cycle
    // free deliberately does not open up room.
    assign full        = (count == NONE_IDX);
    assign empty       = (count == '0);
    assign alloc_ready = !full && !flush;
    assign alloc_fire  = alloc_valid && alloc_ready;

    // Priority search for the lowest invalid slot. Scanning downward lets the
    // last assignment win, which is the lowest index.
    always_comb begin
        alloc_idx = NONE_IDX;
        for (int i = NUM_ID - 1; i >= 0; i--) begin
            if (!valid_out[i]) begin
                alloc_idx = IDX_WIDTH'(i);
            end
        end
    end

    // One-hot decode of the alloc target and of the free target. The free
    // mask only has a bit set when the index is in range and the slot is
    // currently valid, so out-of-range or stale frees simply fall away.
    always_comb begin
        alloc_mask = '0;
        free_mask  = '0;
        for (int i = 0; i < NUM_ID; i++) begin
            alloc_mask[i] = alloc_fire && (alloc_idx == IDX_WIDTH'(i));
            free_mask[i]  = free_valid && (free_idx == IDX_WIDTH'(i)) && valid_out[i];
        end
    end

    assign free_ok = |free_mask;

    // Alloc and free never hit the same slot, so the count moves by at most
    // one and a simultaneous pair leaves it unchanged.
    always_comb begin
        count_next = count;
        if (alloc_fire && !free_ok) begin
            count_next = count + IDX_WIDTH'(1);
        end else if (!alloc_fire && free_ok) begin
            count_next = count - IDX_WIDTH'(1);
        end
    end

    // Associative search over the pre-edge contents; lowest matching valid
    // slot wins, duplicates are allowed.
    always_comb begin
        lookup_hit = 1'b0;
        lookup_idx = NONE_IDX;
        for (int i = NUM_ID - 1; i >= 0; i--) begin
            if (valid_out[i] && (id_array_out[i] == lookup_id)) begin
                lookup_hit = 1'b1;
                lookup_idx = IDX_WIDTH'(i);
            end
        end
    end

    // Slot state. Flush clears the valid bits and count but leaves the stored
    // IDs alone; any alloc or free in the same cycle is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out <= '0;
            count     <= '0;
            for (int i = 0; i < NUM_ID; i++) begin
                id_array_out[i] <= '0;
            end
        end else if (flush) begin
            valid_out <= '0;
            count     <= '0;
        end else begin
            valid_out <= (valid_out | alloc_mask) & ~free_mask;
            count     <= count_next;
            for (int i = 0; i < NUM_ID; i++) begin
                if (alloc_mask[i]) begin
                    id_array_out[i] <= alloc_id;
                end
            end
        end
    end

    // Lookup response register. Hit and index only update when a lookup is
    // accepted so the last answer stays visible between requests.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_hit   <= 1'b0;
            resp_idx   <= NONE_IDX;
        end else begin
            resp_valid <= lookup_valid;
            if (lookup_valid) begin
                resp_hit <= lookup_hit;
                resp_idx <= lookup_idx;
            end
        end
    end

`ifdef ID_TABLE_ERR_CHECK_EN
    logic free_err;
    logic alloc_err;

    assign free_err  = free_valid && !free_ok;
    assign alloc_err = alloc_valid && full && !flush;

    // Sticky error: once set it stays until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (free_err || alloc_err) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_id_table.sv
// ---------------------------------------------------------------------------
// tb_id_table
//
// Self-checking bench for id_table with NUM_ID=4, ID_WIDTH=8. The driver
// steps a slot-array reference model at every rising edge and pushes the
// expected lookup-response registers into a queue; a monitor pops one entry
// per cycle on the falling edge and compares. Table state (valid bits, IDs,
// count, flags, err) and the combinational alloc outputs are compared by the
// driver against the same model.
// ---------------------------------------------------------------------------
module tb_id_table;

    localparam int NID = 4;
    localparam int IW  = 8;
    localparam int XW  = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          alloc_valid;
    logic          alloc_ready;
    logic [IW-1:0] alloc_id;
    logic [XW-1:0] alloc_idx;
    logic          free_valid;
    logic [XW-1:0] free_idx;
    logic          flush;
    logic          lookup_valid;
    logic [IW-1:0] lookup_id;
    logic          resp_valid;
    logic          resp_hit;
    logic [XW-1:0] resp_idx;
    logic [IW-1:0] id_array_out [NID-1:0];
    logic [NID-1:0] valid_out;
    logic [XW-1:0] count;
    logic          full;
    logic          empty;
    logic          err;

    typedef struct packed {
        logic          v;
        logic          h;
        logic [XW-1:0] idx;
    } resp_t;

    resp_t sb_q[$];

    int total = 0;
    int bad   = 0;

    // Reference model: plain arrays describing what the table holds.
    logic          m_valid [NID];
    logic [IW-1:0] m_id    [NID];
    logic          m_err;
    logic          m_last_hit;
    int            m_last_idx;
    bit            started = 1'b0;

    always #5 clk = ~clk;

    id_table #(
        .ID_WIDTH (IW),
        .NUM_ID   (NID),
        .IDX_WIDTH(XW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .alloc_valid (alloc_valid),
        .alloc_ready (alloc_ready),
        .alloc_id    (alloc_id),
        .alloc_idx   (alloc_idx),
        .free_valid  (free_valid),
        .free_idx    (free_idx),
        .flush       (flush),
        .lookup_valid(lookup_valid),
        .lookup_id   (lookup_id),
        .resp_valid  (resp_valid),
        .resp_hit    (resp_hit),
        .resp_idx    (resp_idx),
        .id_array_out(id_array_out),
        .valid_out   (valid_out),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .err         (err)
    );

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int modelCount();
        int n = 0;
        for (int i = 0; i < NID; i++) if (m_valid[i]) n++;
        return n;
    endfunction

    function automatic int modelFirstFree();
        for (int i = 0; i < NID; i++) if (!m_valid[i]) return i;
        return NID;
    endfunction

    // Compare registered table state against the model.
    task automatic checkOutput();
        int n;
        logic [NID-1:0] vexp;
        n = modelCount();
        for (int i = 0; i < NID; i++) vexp[i] = m_valid[i];
        checkVal("valid_out", 32'(valid_out), 32'(vexp));
        checkVal("count", 32'(count), 32'(n));
        checkVal("full", 32'(full), 32'(n == NID));
        checkVal("empty", 32'(empty), 32'(n == 0));
        checkVal("err", 32'(err), 32'(m_err));
        for (int i = 0; i < NID; i++) begin
            checkVal($sformatf("id_array_out[%0d]", i), 32'(id_array_out[i]), 32'(m_id[i]));
        end
    endtask

    // Advance the model across one rising edge using the inputs just driven.
    task automatic modelStep(input bit r, input bit f, input bit av, input logic [IW-1:0] aid,
                             input bit fv, input logic [XW-1:0] fi, input bit lv,
                             input logic [IW-1:0] lid);
        resp_t e;
        bit    hit;
        int    hidx;
        int    slot;
        bit    fok;
        hit  = 1'b0;
        hidx = NID;
        for (int i = 0; i < NID; i++) begin
            if (!hit && m_valid[i] && m_id[i] == lid) begin
                hit  = 1'b1;
                hidx = i;
            end
        end
        if (r) begin
            for (int i = 0; i < NID; i++) begin
                m_valid[i] = 1'b0;
                m_id[i]    = '0;
            end
            m_err      = 1'b0;
            m_last_hit = 1'b0;
            m_last_idx = NID;
            e.v        = 1'b0;
        end else begin
`ifdef ID_TABLE_ERR_CHECK_EN
            if (fv && (int'(fi) >= NID || !m_valid[fi])) m_err = 1'b1;
            if (av && modelCount() == NID && !f) m_err = 1'b1;
`endif
            if (lv) begin
                m_last_hit = hit;
                m_last_idx = hidx;
            end
            e.v  = lv;
            fok  = fv && int'(fi) < NID && m_valid[fi];
            slot = modelFirstFree();
            if (f) begin
                for (int i = 0; i < NID; i++) m_valid[i] = 1'b0;
            end else begin
                if (fok) m_valid[fi] = 1'b0;
                if (av && slot < NID) begin
                    m_valid[slot] = 1'b1;
                    m_id[slot]    = aid;
                end
            end
        end
        e.h   = m_last_hit;
        e.idx = XW'(m_last_idx);
        sb_q.push_back(e);
        started = 1'b1;
    endtask

    // Drive one cycle of inputs, check combinational outputs, then step the
    // model at the rising edge.
    task automatic applyStimulus(input bit r, input bit f, input bit av, input logic [IW-1:0] aid,
                                 input bit fv, input logic [XW-1:0] fi, input bit lv,
                                 input logic [IW-1:0] lid);
        @(negedge clk);
        if (started) checkOutput();
        rst          = r;
        flush        = f;
        alloc_valid  = av;
        alloc_id     = aid;
        free_valid   = fv;
        free_idx     = fi;
        lookup_valid = lv;
        lookup_id    = lid;
        #1;
        if (started) begin
            checkVal("alloc_ready", 32'(alloc_ready), 32'(modelCount() != NID && !f));
            checkVal("alloc_idx", 32'(alloc_idx), 32'(modelFirstFree()));
        end
        @(posedge clk);
        modelStep(r, f, av, aid, fv, fi, lv, lid);
    endtask

    // Monitor: one expected response register image per modelled edge.
    always @(negedge clk) begin
        resp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checkVal("resp_valid", 32'(resp_valid), 32'(e.v));
            checkVal("resp_hit", 32'(resp_hit), 32'(e.h));
            checkVal("resp_idx", 32'(resp_idx), 32'(e.idx));
        end
    end

    function automatic logic [IW-1:0] pickId();
        logic [IW-1:0] pool [4];
        pool[0] = 8'h11;
        pool[1] = 8'h7A;
        pool[2] = 8'hC3;
        pool[3] = IW'($urandom);
        return pool[$urandom_range(0, 3)];
    endfunction

    initial begin
        rst = 1'b1; flush = 1'b0; alloc_valid = 1'b0; alloc_id = '0;
        free_valid = 1'b0; free_idx = '0; lookup_valid = 1'b0; lookup_id = '0;

        // Reset, then fill the table back to back.
        applyStimulus(1, 0, 0, 8'h00, 0, 0, 0, 8'h00);
        applyStimulus(1, 0, 0, 8'h00, 0, 0, 0, 8'h00);
        applyStimulus(0, 0, 1, 8'h11, 0, 0, 0, 8'h00);
        applyStimulus(0, 0, 1, 8'h22, 0, 0, 0, 8'h00);
        applyStimulus(0, 0, 1, 8'h33, 0, 0, 0, 8'h00);
        applyStimulus(0, 0, 1, 8'h44, 0, 0, 0, 8'h00);
        applyStimulus(0, 0, 0, 8'h00, 0, 0, 0, 8'h00);
        // Alloc attempt while full is refused.
        applyStimulus(0, 0, 1, 8'h99, 0, 0, 0, 8'h00);

        // Free slot 1, refill with 0x55, look it up.
        applyStimulus(0, 0, 0, 8'h00, 1, 3'd1, 0, 8'h00);
        applyStimulus(0, 0, 1, 8'h55, 0, 0, 0, 8'h00);
        applyStimulus(0, 0, 0, 8'h00, 0, 0, 1, 8'h55);

        // Duplicate 0x7A in slots 0 and 2.
        applyStimulus(0, 0, 0, 8'h00, 1, 3'd0, 0, 8'h00);
        applyStimulus(0, 0, 1, 8'h7A, 0, 0, 0, 8'h00);
        applyStimulus(0, 0, 0, 8'h00, 1, 3'd2, 0, 8'h00);
        applyStimulus(0, 0, 1, 8'h7A, 0, 0, 0, 8'h00);
        applyStimulus(0, 0, 0, 8'h00, 0, 0, 1, 8'h7A);
        applyStimulus(0, 0, 0, 8'h00, 1, 3'd0, 1, 8'h7A);
        applyStimulus(0, 0, 0, 8'h00, 0, 0, 1, 8'h7A);
        applyStimulus(0, 0, 0, 8'h00, 0, 0, 0, 8'h00);

        // Flush with alloc and free pending, then a lookup that must miss.
        applyStimulus(0, 1, 1, 8'hAB, 1, 3'd1, 0, 8'h00);
        applyStimulus(0, 0, 0, 8'h00, 0, 0, 1, 8'h55);
        applyStimulus(0, 0, 0, 8'h00, 0, 0, 0, 8'h00);

        // Free of an empty slot and an out-of-range index.
        applyStimulus(0, 0, 0, 8'h00, 1, 3'd3, 0, 8'h00);
        applyStimulus(0, 0, 0, 8'h00, 1, 3'd6, 0, 8'h00);
        applyStimulus(0, 0, 1, 8'h21, 0, 0, 0, 8'h00);
        applyStimulus(0, 0, 1, 8'h42, 0, 0, 1, 8'h21);
        // Reset with a lookup pending drops it.
        applyStimulus(1, 0, 1, 8'h63, 0, 0, 1, 8'h21);
        applyStimulus(0, 0, 0, 8'h00, 0, 0, 0, 8'h00);

        // Randomised traffic.
        for (int n = 0; n < 600; n++) begin
            applyStimulus($urandom_range(0, 59) == 0,
                          $urandom_range(0, 19) == 0,
                          $urandom_range(0, 1) == 1,
                          pickId(),
                          $urandom_range(0, 2) == 0,
                          XW'($urandom_range(0, 7)),
                          $urandom_range(0, 1) == 1,
                          pickId());
        end

        applyStimulus(0, 0, 0, 8'h00, 0, 0, 0, 8'h00);
        @(negedge clk);
        #1;
        checkVal("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
